// File: rtl/fsk_demod_framer.sv
// fsk_demod_framer
//   Counts rising edges of an asynchronous FSK carrier over fixed bit periods,
//   decodes each period as 1 (count >= EDGE_THRESH) or 0, and assembles
//   FRAME_BITS decoded bits into a frame.
//
// Ports
//   clk          rising-edge clock for all logic
//   reset        asynchronous active-low reset
//   en           demodulation enable; low clears timing and frame assembly
//   bit_sync     restarts bit timing and discards the partial frame
//   fsk_signal   asynchronous FSK carrier input
//   frame_data   last completed frame, held between frames
//   frame_valid  one-cycle pulse in the cycle after a frame is loaded
//                (no ready: the consumer must take frame_data on this pulse
//                or before the next frame completes)
//   carrier_lost last completed bit period saw zero edges
//   bit_index    position of the bit currently being received
module fsk_demod_framer #(
   parameter int FRAME_BITS  = 14,
   parameter int BIT_CYCLES  = 64,
   parameter int CNT_W       = 8,
   parameter int EDGE_THRESH = 4,
   parameter int MSB_FIRST   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          bit_sync,
   input  logic                          fsk_signal,
   output logic [FRAME_BITS-1:0]         frame_data,
   output logic                          frame_valid,
   output logic                          carrier_lost,
   output logic [$clog2(FRAME_BITS)-1:0] bit_index
);

   localparam int IDX_W = $clog2(FRAME_BITS);
   localparam int TMR_W = $clog2(BIT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] THRESH   = CNT_W'(EDGE_THRESH);

   logic                  r_s1, r_s2, r_s3;
   logic [TMR_W-1:0]      r_timer;
   logic [CNT_W-1:0]      r_count;
   logic [FRAME_BITS-1:0] r_shift;
   logic [IDX_W-1:0]      r_idx;
   logic [FRAME_BITS-1:0] r_frame;
   logic                  r_valid;
   logic                  r_lost;

   logic                  w_strobe;
   logic                  w_bit_end;
   logic [CNT_W-1:0]      w_count_next;
   logic                  w_bit;
   logic [FRAME_BITS-1:0] w_shift_next;

   // s1/s2 resolve metastability; s3 delays s2 so a rising edge shows as s2 & ~s3
   assign w_strobe  = r_s2 & ~r_s3;
   assign w_bit_end = (r_timer == TMR_LAST);

   // Count including a strobe in this cycle, so a strobe on bit_end still
   // belongs to the ending bit. Saturates instead of wrapping.
   assign w_count_next = (w_strobe && !(&r_count)) ? r_count + 1'b1 : r_count;
   assign w_bit        = (w_count_next >= THRESH);

   if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_next = {r_shift[FRAME_BITS-2:0], w_bit};
   end else begin : g_lsb_first
      assign w_shift_next = {w_bit, r_shift[FRAME_BITS-1:1]};
   end

   // Synchronizer runs regardless of en or bit_sync
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= fsk_signal;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
         r_count <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_frame <= '0;
         r_valid <= 1'b0;
         r_lost  <= 1'b0;
      end else if (!en || bit_sync) begin
         // Restart: drop the partial frame; a coincident bit_end is ignored.
         // frame_data and carrier_lost keep their last values.
         r_timer <= '0;
         r_count <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_bit_end) begin
            r_timer <= '0;
            r_count <= '0;
            r_shift <= w_shift_next;
            r_lost  <= (w_count_next == '0);
            if (r_idx == IDX_LAST) begin
               r_idx   <= '0;
               r_frame <= w_shift_next;
               r_valid <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end else begin
            r_timer <= r_timer + 1'b1;
            r_count <= w_count_next;
         end
      end
   end

   assign frame_data   = r_frame;
   assign frame_valid  = r_valid;
   assign carrier_lost = r_lost;
   assign bit_index    = r_idx;

endmodule

// File: tb/tb_fsk_demod_framer.sv
module tb_fsk_demod_framer;

   localparam int FB = 14;
   localparam int BC = 64;
   localparam int TH = 4;

   // ---------------- clock / reset ----------------
   logic clk        = 1'b0;
   logic reset      = 1'b1;
   logic en         = 1'b0;
   logic bit_sync   = 1'b0;
   logic fsk_signal = 1'b0;

   always #5 clk = ~clk;

   logic [FB-1:0] fd_a, fd_b, fd_c;
   logic          fv_a, fv_b, fv_c;
   logic          cl_a, cl_b, cl_c;
   logic [3:0]    bi_a, bi_b, bi_c;

   // a: defaults, b: LSB-first, c: narrow saturating counter
   fsk_demod_framer dut_a (
      .clk(clk), .reset(reset), .en(en), .bit_sync(bit_sync), .fsk_signal(fsk_signal),
      .frame_data(fd_a), .frame_valid(fv_a), .carrier_lost(cl_a), .bit_index(bi_a));

   fsk_demod_framer #(.MSB_FIRST(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .bit_sync(bit_sync), .fsk_signal(fsk_signal),
      .frame_data(fd_b), .frame_valid(fv_b), .carrier_lost(cl_b), .bit_index(bi_b));

   fsk_demod_framer #(.CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .en(en), .bit_sync(bit_sync), .fsk_signal(fsk_signal),
      .frame_data(fd_c), .frame_valid(fv_c), .carrier_lost(cl_c), .bit_index(bi_c));

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;               // index of the last rising clock edge
   logic pin_hist [0:16383];     // pin value sampled at each edge
   int pulses_a = 0, pulses_b = 0, pulses_c = 0;
   int exp_frames = 0;

   int            win_start;     // first edge of the bit window being received
   int            nbit;
   logic          bit_q[$];      // decoded bits of the current frame, in arrival order
   logic [FB-1:0] exp_fd_a = '0, exp_fd_b = '0;
   logic          exp_cl_a = 1'b0, exp_cl_c = 1'b0;

   always @(negedge clk) begin
      if (fv_a) pulses_a++;
      if (fv_b) pulses_b++;
      if (fv_c) pulses_c++;
   end

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick(input logic p, input logic sync);
      fsk_signal = p;
      bit_sync   = sync;
      @(posedge clk);
      cyc++;
      pin_hist[cyc] = p;
      @(negedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // A pin rise first sampled at edge j is seen by the counter at edge j+2.
   function automatic int model_count(input int ws);
      int cnt = 0;
      for (int e = ws; e < ws + BC; e++)
         if (e >= 3 && pin_hist[e-2] && !pin_hist[e-3]) cnt++;
      return cnt;
   endfunction

   task automatic start_frame(input int first_edge);
      win_start = first_edge;
      nbit      = 0;
      bit_q.delete();
   endtask

   task automatic decode_bit();
      int cnt, sat_c;
      logic b;
      logic [FB-1:0] fa, fb;
      cnt   = model_count(win_start);
      sat_c = (cnt > 15) ? 15 : cnt;
      b     = (cnt >= TH);
      exp_cl_a = (cnt == 0);
      exp_cl_c = (sat_c == 0);
      bit_q.push_back(b);
      nbit++;
      win_start += BC;
      chk("bit_index", 32'(bi_a), 32'(nbit % FB));
      chk("carrier_lost_a", 32'(cl_a), 32'(exp_cl_a));
      chk("carrier_lost_c", 32'(cl_c), 32'(exp_cl_c));
      if (nbit == FB) begin
         fa = '0;
         fb = '0;
         for (int i = 0; i < FB; i++) begin
            fa[FB-1-i] = bit_q[i];
            fb[i]      = bit_q[i];
         end
         exp_fd_a = fa;
         exp_fd_b = fb;
         exp_frames++;
         chk("frame_valid_a", 32'(fv_a), 32'd1);
         chk("frame_valid_b", 32'(fv_b), 32'd1);
         chk("frame_valid_c", 32'(fv_c), 32'd1);
         chk("frame_data_a", 32'(fd_a), 32'(exp_fd_a));
         chk("frame_data_b", 32'(fd_b), 32'(exp_fd_b));
         chk("frame_data_c", 32'(fd_c), 32'(exp_fd_a));
         nbit = 0;
         bit_q.delete();
      end else begin
         chk("frame_valid_idle", 32'(fv_a), 32'd0);
      end
   endtask

   // period 0 = flat low; otherwise square wave of the given period limited to k rises
   task automatic drive_bit(input int period, input int k);
      logic p;
      for (int c = 0; c < BC; c++) begin
         p = (period != 0) && ((c % period) >= period / 2) && ((c / period) < k);
         tick(p, 1'b0);
      end
      decode_bit();
   endtask

   task automatic random_bit();
      case ($urandom_range(0, 4))
         0:       drive_bit(0, 0);
         1:       drive_bit(2, 99);
         2:       drive_bit(8, 99);
         3:       drive_bit(32, 99);
         default: drive_bit(16, $urandom_range(1, 4));
      endcase
   endtask

   task automatic random_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic check_pulses(input string tag);
      chk({tag, "_pulses_a"}, 32'(pulses_a), 32'(exp_frames));
      chk({tag, "_pulses_b"}, 32'(pulses_b), 32'(exp_frames));
      chk({tag, "_pulses_c"}, 32'(pulses_c), 32'(exp_frames));
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_fd_a"}, 32'(fd_a), 32'd0);
      chk({tag, "_fd_b"}, 32'(fd_b), 32'd0);
      chk({tag, "_fv_a"}, 32'(fv_a), 32'd0);
      chk({tag, "_cl_a"}, 32'(cl_a), 32'd0);
      chk({tag, "_cl_c"}, 32'(cl_c), 32'd0);
      chk({tag, "_bi_a"}, 32'(bi_a), 32'd0);
      chk({tag, "_bi_b"}, 32'(bi_b), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [FB-1:0] word;
      word = 14'h25A3;

      // reset state
      #1 reset = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check_cleared("reset");

      // bit_sync then 0x25A3: 1 = 8-clk carrier, 0 = 32-clk carrier
      reset = 1'b1;
      en    = 1'b1;
      tick(1'b0, 1'b1);
      start_frame(cyc + 1);
      for (int i = 0; i < FB; i++) drive_bit(word[FB-1-i] ? 8 : 32, 99);

      // boundaries, continuing into the next frame without resync:
      // no carrier, 8 edges, 3 edges, 4 edges, 2-clk carrier (saturates narrow counter)
      drive_bit(0, 0);
      drive_bit(8, 99);
      drive_bit(8, 3);
      drive_bit(8, 4);
      drive_bit(2, 99);
      for (int i = 0; i < FB - 5; i++) random_bit();
      check_pulses("seg2");

      // bit_sync in the middle of bit 9, then again exactly on a bit_end
      for (int i = 0; i < 9; i++) random_bit();
      random_ticks($urandom_range(1, 60));
      tick(1'($urandom_range(0, 1)), 1'b1);
      start_frame(cyc + 1);
      chk("sync_mid_bi", 32'(bi_a), 32'd0);
      check_pulses("sync_mid");
      random_ticks(BC - 1);
      tick(1'($urandom_range(0, 1)), 1'b1);
      start_frame(cyc + 1);
      chk("sync_end_bi", 32'(bi_a), 32'd0);
      chk("sync_end_cl", 32'(cl_a), 32'(exp_cl_a));
      check_pulses("sync_end");
      for (int i = 0; i < FB; i++) random_bit();

      // en=0 at bit 7: outputs hold, indices clear, no pulse
      for (int i = 0; i < 7; i++) random_bit();
      random_ticks($urandom_range(1, 60));
      en = 1'b0;
      random_ticks(2);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      chk("en_off_fv", 32'(fv_a), 32'd0);
      chk("en_off_bi", 32'(bi_a), 32'd0);
      chk("en_off_fd_a", 32'(fd_a), 32'(exp_fd_a));
      chk("en_off_fd_b", 32'(fd_b), 32'(exp_fd_b));
      chk("en_off_cl", 32'(cl_a), 32'(exp_cl_a));
      check_pulses("en_off");
      en = 1'b1;
      start_frame(cyc + 1);
      for (int i = 0; i < FB; i++) random_bit();

      // asynchronous reset at bit 7
      for (int i = 0; i < 7; i++) random_bit();
      random_ticks($urandom_range(1, 60));
      #1 reset = 1'b0;
      #1;
      check_cleared("async_rst");
      exp_fd_a = '0;
      exp_fd_b = '0;
      exp_cl_a = 1'b0;
      exp_cl_c = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      check_pulses("in_rst");
      reset = 1'b1;
      start_frame(cyc + 1);
      for (int i = 0; i < FB; i++) random_bit();

      check_pulses("final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
